// File: rtl/piano_pkg.sv
// Shared types and helpers for the piano key front end.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package piano_pkg;

    localparam int         NUM_KEYS = 12;
    localparam int         OCT_W    = 4;
    localparam int         IDX_W    = 4;
    localparam logic [3:0] OCT_MAX  = 4'd8;

    // One note event as seen by the tone generator.
    typedef struct packed {
        logic             on;
        logic [IDX_W-1:0] idx;
        logic [OCT_W-1:0] oct;
    } note_t;

    // Event handshake state.
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } ev_state_t;

    // Octave selects above the top playable octave fold onto it.
    function automatic logic [OCT_W-1:0] clamp_oct(input logic [OCT_W-1:0] oct);
        return (oct > OCT_MAX) ? OCT_MAX : oct;
    endfunction

    // Highest pitch wins: bit 0 is B, the highest key, so the lowest set
    // bit index b is selected and reported as note 11-b.
    function automatic note_t encode_keys(input logic [NUM_KEYS-1:0] keys,
                                          input logic [OCT_W-1:0]    oct);
        note_t n;
        n.on  = 1'b0;
        n.idx = '0;
        n.oct = clamp_oct(oct);
        // Walk from the lowest pitch upward so the last hit is the highest.
        for (int b = NUM_KEYS - 1; b >= 0; b--) begin
            if (keys[b]) begin
                n.on  = 1'b1;
                n.idx = IDX_W'(NUM_KEYS - 1 - b);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser plus a shared-window debouncer for a bus of raw inputs.
// Latency: stable output follows a settled input DEBOUNCE_CYCLES+2 edges after it is sampled.
// Backpressure: none; free-running, any bit change restarts the window for the whole bus.
module input_debounce #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 5000,
    parameter int CNT_W           = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q,  sync1_d;
    logic [WIDTH-1:0] sync2_q,  sync2_d;
    logic [WIDTH-1:0] cand_q,   cand_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    // Synchronise, then track how long the synchronised bus has held one value.
    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != cand_q) begin
            // New value: restart the quiet window from zero.
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Window complete: keep committing and park the counter here.
            stable_d = cand_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/key_note_encoder.sv
// Debounces keys and octave, priority-encodes the highest pressed key, and emits note events.
// Latency: note_valid rises DEBOUNCE_CYCLES+4 edges after a settled input is first sampled.
// Backpressure: one event held frozen until note_ready; newer states coalesce into the next event.
module key_note_encoder
    import piano_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 5000,
    parameter int CNT_W           = 13
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys_in,
    input  logic [OCT_W-1:0]    octave_in,
    output logic                note_valid,
    input  logic                note_ready,
    output logic                note_on,
    output logic [IDX_W-1:0]    note_idx,
    output logic [OCT_W-1:0]    note_oct,
    output logic [NUM_KEYS-1:0] key_stable
);

    logic [NUM_KEYS+OCT_W-1:0] deb_stable;
    logic [NUM_KEYS-1:0]       keys_stable;
    logic [OCT_W-1:0]          oct_stable;

    note_t     cur_q,   cur_d;
    note_t     last_q,  last_d;
    note_t     out_q,   out_d;
    logic      valid_q, valid_d;
    ev_state_t state_q, state_d;
    logic      differs;

    // Keys and octave share one debounce window so they settle together.
    input_debounce #(
        .WIDTH           (NUM_KEYS + OCT_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  ({keys_in, octave_in}),
        .dout (deb_stable)
    );

    assign keys_stable = deb_stable[NUM_KEYS+OCT_W-1:OCT_W];
    assign oct_stable  = deb_stable[OCT_W-1:0];

    // Clamp and priority encode the debounced state into the current note.
    always_comb begin
        cur_d = encode_keys(keys_stable, oct_stable);
    end

    // An octave change while silent is not worth an event; otherwise any difference is.
    assign differs = (cur_q.on || last_q.on) && (cur_q != last_q);

    // Event FSM: launch a snapshot of cur, hold it until accepted, then re-compare.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        last_d  = last_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (differs) begin
                    out_d   = cur_q;
                    valid_d = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (note_ready) begin
                    last_d  = out_q;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Registers for the encoded note, the handshake and the last accepted event.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q   <= '0;
            last_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            state_q <= IDLE;
        end else begin
            cur_q   <= cur_d;
            last_q  <= last_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end

    assign note_valid = valid_q;
    assign note_on    = out_q.on;
    assign note_idx   = out_q.idx;
    assign note_oct   = out_q.oct;
    assign key_stable = keys_stable;

endmodule

// File: tb/tb_key_note_encoder.sv
module tb_key_note_encoder;

    localparam int D = 4;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic [11:0] keys_in    = 12'h000;
    logic [3:0]  octave_in  = 4'd0;
    logic        note_ready = 1'b1;
    logic        note_valid;
    logic        note_on;
    logic [3:0]  note_idx;
    logic [3:0]  note_oct;
    logic [11:0] key_stable;

    always #5 clk = ~clk;

    key_note_encoder #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .keys_in    (keys_in),
        .octave_in  (octave_in),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_on    (note_on),
        .note_idx   (note_idx),
        .note_oct   (note_oct),
        .key_stable (key_stable)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Debounce as a run length of identical synchronised samples; events as
    // "pending snapshot" + "last accepted" notes.
    logic [11:0] m_keys;
    logic [3:0]  m_oct;
    logic [15:0] m_s1, m_s2;
    int          m_run;
    logic [8:0]  m_cur, m_last, m_data;
    logic        m_valid;
    bit          m_init = 1'b0;

    function automatic logic [8:0] m_encode(input logic [11:0] k, input logic [3:0] o);
        logic [3:0] oc;
        oc = (o > 4'd8) ? 4'd8 : o;
        for (int b = 0; b < 12; b++)
            if (k[b]) return {1'b1, 4'(11 - b), oc};
        return {1'b0, 4'd0, oc};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_run = 1;
            m_keys = '0; m_oct = '0;
            m_cur = '0; m_last = '0; m_data = '0; m_valid = 1'b0;
            m_init = 1'b1;
        end else begin
            if (m_valid) begin
                if (note_ready) begin
                    m_last  = m_data;
                    m_valid = 1'b0;
                end
            end else if ((m_cur[8] || m_last[8]) && m_cur != m_last) begin
                m_data  = m_cur;
                m_valid = 1'b1;
            end
            m_cur = m_encode(m_keys, m_oct);
            if (m_run >= D + 1) {m_keys, m_oct} = m_s2;
            if (m_s1 == m_s2) begin
                if (m_run < D + 1) m_run++;
            end else begin
                m_run = 1;
            end
            m_s2 = m_s1;
            m_s1 = {keys_in, octave_in};
        end
        cyc++;
    end

    // ---------------- compare process ----------------
    logic        pv = 1'b0;
    logic [8:0]  pd = '0;
    logic [11:0] pks = '0;
    int          ks_changes = 0;
    logic [8:0]  acc_q[$];

    always @(negedge clk) begin
        if (m_init) begin
            chk("key_stable", 16'(key_stable), 16'(m_keys));
            chk("note_valid", 16'(note_valid), 16'(m_valid));
            if (m_valid) chk("note_data", 16'({note_on, note_idx, note_oct}), 16'(m_data));
            if (pv && !note_ready && !rst)
                chk("frozen_data", 16'({note_valid, note_on, note_idx, note_oct}), 16'({1'b1, pd}));
            if (pv && note_ready && !rst) acc_q.push_back(pd);
            if (key_stable !== pks) ks_changes++;
            pks = key_stable;
            pv  = note_valid;
            pd  = {note_on, note_idx, note_oct};
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_valid(input string name, input int lim);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (note_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: note_valid not seen within %0d cycles", name, lim);
        end
    endtask

    task automatic chk_last(input string name, input logic [8:0] exp);
        if (acc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no accepted event, expected %h", name, exp);
        end else begin
            chk(name, 16'(acc_q[acc_q.size() - 1]), 16'(exp));
        end
    endtask

    initial begin
        int t;
        int n0;

        // Reset
        rst = 1'b1; keys_in = 12'h000; octave_in = 4'd4; note_ready = 1'b1;
        steps(2);
        chk("reset_valid", 16'(note_valid), 16'h0);
        chk("reset_key_stable", 16'(key_stable), 16'h0);
        chk("reset_note_on", 16'(note_on), 16'h0);
        rst = 1'b0;
        steps(10);
        chk("no_event_after_reset", 16'(acc_q.size()), 16'd0);

        // Single key: valid rises at t+8 for exactly one cycle
        step();
        keys_in = 12'h800;
        t = cyc + 1;
        wait_valid("single_wait", 40);
        chk("single_rise_edge", 16'(cyc), 16'(t + 8));
        chk("single_data", 16'({note_on, note_idx, note_oct}), 16'({1'b1, 4'd0, 4'd4}));
        step();
        chk("single_one_cycle", 16'(note_valid), 16'h0);
        steps(10);

        // Bounce on bit 0, then hold
        n0 = acc_q.size();
        ks_changes = 0;
        for (int p = 0; p < 5; p++) begin
            keys_in = 12'h801; steps(3);
            keys_in = 12'h800; steps(3);
        end
        keys_in = 12'h801;
        steps(20);
        chk("bounce_event_count", 16'(acc_q.size() - n0), 16'd1);
        chk_last("bounce_event", {1'b1, 4'd11, 4'd4});
        chk("bounce_stable_changes", 16'(ks_changes), 16'd1);

        // Priority and octave clamp
        keys_in = 12'h881; octave_in = 4'd13;
        steps(20);
        chk_last("priority_clamp", {1'b1, 4'd11, 4'd8});
        keys_in = 12'h880;
        steps(20);
        chk_last("priority_release_b0", {1'b1, 4'd4, 4'd8});

        // Coalescing while the first event is pending
        n0 = acc_q.size();
        note_ready = 1'b0;
        keys_in = 12'h800;
        wait_valid("coalesce_wait", 40);
        keys_in = 12'h400; steps(10);
        keys_in = 12'h200; steps(10);
        chk("coalesce_still_pending", 16'({note_valid, note_idx}), 16'({1'b1, 4'd0}));
        note_ready = 1'b1;
        steps(20);
        chk("coalesce_count", 16'(acc_q.size() - n0), 16'd2);
        if (acc_q.size() >= n0 + 2) begin
            chk("coalesce_first", 16'(acc_q[n0]), 16'({1'b1, 4'd0, 4'd8}));
            chk("coalesce_second", 16'(acc_q[n0 + 1]), 16'({1'b1, 4'd2, 4'd8}));
        end

        // Release, then an octave change alone
        n0 = acc_q.size();
        keys_in = 12'h000;
        steps(20);
        chk("release_count", 16'(acc_q.size() - n0), 16'd1);
        chk_last("release_event", {1'b0, 4'd0, 4'd8});
        n0 = acc_q.size();
        octave_in = 4'd2;
        steps(20);
        chk("silent_octave_no_event", 16'(acc_q.size() - n0), 16'd0);

        // Reset while an event is pending
        note_ready = 1'b0;
        keys_in = 12'h020; octave_in = 4'd3;
        wait_valid("pend_wait", 40);
        rst = 1'b1;
        step();
        chk("midreset_valid", 16'(note_valid), 16'h0);
        chk("midreset_key_stable", 16'(key_stable), 16'h0);
        rst = 1'b0;
        note_ready = 1'b1;
        wait_valid("fresh_wait", 40);
        chk("fresh_event", 16'({note_on, note_idx, note_oct}), 16'({1'b1, 4'd6, 4'd3}));
        steps(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
